// File: rtl/frame_config_loader.sv
// Frame configuration writer: parses a 32-bit word stream into one fabric frame and fires a one-hot FrameStrobe.
// Optional macro CONFIG_CRC_EN adds a trailing XOR check word per frame that gates the strobe.
module frame_config_loader #(
   parameter int NumberOfRows    = 16,
   parameter int NumberOfCols    = 8,
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20
) (
   input  logic                                      CLK,
   input  logic                                      resetn,
   input  logic [31:0]                               WriteData,
   input  logic                                      WriteStrobe,
   output logic                                      Ready,
   output logic [FrameBitsPerRow*NumberOfRows-1:0]   FrameData,
   output logic [MaxFramesPerCol*NumberOfCols-1:0]   FrameStrobe,
   output logic                                      Busy,
   output logic                                      Error
);

   localparam int         ROW_W    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
   localparam int         STROBE_W = MaxFramesPerCol * NumberOfCols;
   localparam int         SIDX_W   = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;
   localparam logic [3:0] MARKER   = 4'hA;

`ifdef CONFIG_CRC_EN
   typedef enum logic [2:0] {S_IDLE, S_DATA, S_CHECK, S_STROBE, S_HOLD} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_DATA, S_STROBE, S_HOLD} state_t;
`endif

   state_t                       state;
   state_t                       state_next;
   logic                         armed;
   logic [7:0]                   col_q;
   logic [7:0]                   frame_q;
   logic [ROW_W-1:0]             row_q;
   logic [FrameBitsPerRow-1:0]   rows [NumberOfRows];
   logic                         error_q;
   logic [STROBE_W-1:0]          strobe_q;
   logic [STROBE_W-1:0]          strobe_next;
   logic [SIDX_W-1:0]            strobe_idx;

   logic accept;
   logic hdr_valid;
   logic last_row;
   logic hdr_load;
   logic row_write;
   logic err_set;
   logic fire;

`ifdef CONFIG_CRC_EN
   logic [31:0] crc_q;
`endif

   // Ready depends only on registered state so the accept handshake has no combinational loop.
   always_comb begin
      Ready = 1'b0;
      case (state)
         S_IDLE:  Ready = armed;
         S_DATA:  Ready = 1'b1;
`ifdef CONFIG_CRC_EN
         S_CHECK: Ready = 1'b1;
`endif
         default: Ready = 1'b0;
      endcase
   end

   assign accept    = WriteStrobe && Ready;
   assign hdr_valid = (WriteData[31:28] == MARKER)
                   && (int'(WriteData[27:20]) < NumberOfCols)
                   && (int'(WriteData[19:12]) < MaxFramesPerCol);
   assign last_row  = (row_q == ROW_W'(NumberOfRows - 1));

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_next;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      hdr_load   = 1'b0;
      row_write  = 1'b0;
      err_set    = 1'b0;
      fire       = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (hdr_valid) begin
                  hdr_load   = 1'b1;
                  state_next = S_DATA;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               row_write = 1'b1;
               if (last_row) begin
`ifdef CONFIG_CRC_EN
                  state_next = S_CHECK;
`else
                  fire       = 1'b1;
                  state_next = S_STROBE;
`endif
               end
            end
         end
`ifdef CONFIG_CRC_EN
         S_CHECK: begin
            if (accept) begin
               if (WriteData == crc_q) begin
                  fire       = 1'b1;
                  state_next = S_STROBE;
               end else begin
                  err_set    = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
`endif
         S_STROBE: state_next = S_HOLD;
         S_HOLD:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Strobe is loaded on the edge that accepts the final word, so it is high in the following cycle only.
   always_comb begin
      strobe_idx              = SIDX_W'(int'(col_q) * MaxFramesPerCol + int'(frame_q));
      strobe_next             = '0;
      strobe_next[strobe_idx] = fire;
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         col_q    <= '0;
         frame_q  <= '0;
         row_q    <= '0;
         error_q  <= 1'b0;
         strobe_q <= '0;
         for (int r = 0; r < NumberOfRows; r++) begin
            rows[r] <= '0;
         end
      end else begin
         strobe_q <= strobe_next;
         if (err_set) begin
            error_q <= 1'b1;
         end
         if (hdr_load) begin
            col_q   <= WriteData[27:20];
            frame_q <= WriteData[19:12];
            row_q   <= '0;
         end else if (row_write) begin
            rows[row_q] <= WriteData[FrameBitsPerRow-1:0];
            if (!last_row) begin
               row_q <= row_q + ROW_W'(1);
            end
         end
      end
   end

`ifdef CONFIG_CRC_EN
   // Running XOR of the header and every data word of the frame being assembled.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         crc_q <= '0;
      end else if (hdr_load) begin
         crc_q <= WriteData;
      end else if (row_write) begin
         crc_q <= crc_q ^ WriteData;
      end
   end
`endif

   for (genvar r = 0; r < NumberOfRows; r++) begin : g_rows
      assign FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows[r];
   end

   assign FrameStrobe = strobe_q;
   assign Busy        = (state != S_IDLE);
   assign Error       = error_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench for frame_config_loader: expected frames queued as words are driven, checked when FrameStrobe fires.
module tb_frame_config_loader;

   logic          CLK;
   logic          resetn;
   logic [31:0]   WriteData;
   logic          WriteStrobe;
   logic          Ready;
   logic [511:0]  FrameData;
   logic [159:0]  FrameStrobe;
   logic          Busy;
   logic          Error;

   frame_config_loader dut (
      .CLK         (CLK),
      .resetn      (resetn),
      .WriteData   (WriteData),
      .WriteStrobe (WriteStrobe),
      .Ready       (Ready),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .Busy        (Busy),
      .Error       (Error)
   );

   typedef struct {
      int           idx;
      logic [511:0] data;
   } sb_t;

   sb_t          sb [$];
   logic [31:0]  exp_rows [16];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           last_acc = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every strobe must match the oldest queued frame; a strobe with nothing queued is an error.
   always @(negedge CLK) begin
      if (resetn && FrameStrobe != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_strobe", {352'd0, FrameStrobe}, 512'd0);
         end else begin
            sb_t          e;
            logic [511:0] oh;
            e      = sb.pop_front();
            oh     = '0;
            oh[e.idx] = 1'b1;
            chk("strobe", {352'd0, FrameStrobe}, oh);
            chk("framedata", FrameData, e.data);
         end
      end
   end

   task automatic push_exp(input logic [31:0] hdr);
      sb_t e;
      e.idx = int'(hdr[27:20]) * 20 + int'(hdr[19:12]);
      for (int r = 0; r < 16; r++) e.data[r*32 +: 32] = exp_rows[r];
      sb.push_back(e);
   endtask

   // Presents a word and leaves WriteStrobe high; returns at the negedge after acceptance.
   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      WriteData   = w;
      WriteStrobe = 1'b1;
      while (!Ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!Ready) begin
         chk("ready_timeout", 512'd0, 512'd1);
      end else begin
         last_acc = cyc + 1;
         @(negedge CLK);
      end
   endtask

   task automatic send_body(input logic [31:0] hdr, input logic [31:0] base, input bit good);
      logic [31:0] x;
      x = hdr;
      for (int r = 0; r < 16; r++) begin
         exp_rows[r] = base + 32'(r);
         x = x ^ (base + 32'(r));
`ifndef CONFIG_CRC_EN
         if (r == 15 && good) push_exp(hdr);
`endif
         send(base + 32'(r));
      end
`ifdef CONFIG_CRC_EN
      if (good) push_exp(hdr);
      send(good ? x : (x ^ 32'd1));
`endif
   endtask

   task automatic idle(input int n);
      WriteStrobe = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      WriteStrobe = 1'b0;
      resetn = 1'b0;
      #1;
      for (int r = 0; r < 16; r++) exp_rows[r] = '0;
      sb.delete();
      chk("rst_framedata", FrameData, 512'd0);
      chk("rst_strobe", {352'd0, FrameStrobe}, 512'd0);
      chk("rst_ready", {511'd0, Ready}, 512'd0);
      chk("rst_busy", {511'd0, Busy}, 512'd0);
      chk("rst_error", {511'd0, Error}, 512'd0);
      @(negedge CLK);
      resetn = 1'b1;
      #1;
      chk("ready_after_release", {511'd0, Ready}, 512'd0);
      @(negedge CLK);
      chk("ready_one_cycle_later", {511'd0, Ready}, 512'd1);
   endtask

   initial begin
      int n;
      logic [31:0] bad [3];
      resetn      = 1'b0;
      WriteStrobe = 1'b0;
      WriteData   = '0;
      for (int r = 0; r < 16; r++) exp_rows[r] = '0;
      do_reset();
      chk("idle_busy", {511'd0, Busy}, 512'd0);

      // Basic frame, column 3 frame 5 -> strobe bit 65.
      send(32'hA030_5000);
      chk("data_busy", {511'd0, Busy}, 512'd1);
      send_body(32'hA030_5000, 32'h1000_0000, 1'b1);
      idle(4);
      chk("frame_error", {511'd0, Error}, 512'd0);
      chk("row3_held", {480'd0, FrameData[3*32 +: 32]}, {480'd0, 32'h1000_0003});
      chk("row15_held", {480'd0, FrameData[15*32 +: 32]}, {480'd0, 32'h1000_000F});

      // Reset in the middle of a stream.
      send(32'hA010_2000);
      for (int r = 0; r < 3; r++) send(32'h5555_0000 + 32'(r));
      do_reset();

      // Bad headers: wrong marker, column out of range, frame out of range.
      bad[0] = 32'h5000_0000;
      bad[1] = 32'hA080_0000;
      bad[2] = 32'hA001_4000;
      for (int i = 0; i < 3; i++) begin
         send(bad[i]);
         idle(1);
         chk("bad_hdr_error", {511'd0, Error}, 512'd1);
         chk("bad_hdr_busy", {511'd0, Busy}, 512'd0);
         if (i < 2) do_reset();
      end
      // Highest legal column/frame after an error: strobe bit 159, Error stays sticky.
      send(32'hA071_3000);
      send_body(32'hA071_3000, 32'h7000_0000, 1'b1);
      idle(4);
      chk("error_sticky", {511'd0, Error}, 512'd1);
      do_reset();

      // Back-to-back frames with WriteStrobe held high through STROBE/HOLD.
      send(32'hA000_0000);
      send_body(32'hA000_0000, 32'h2000_0000, 1'b1);
      n = last_acc;
      send(32'hA020_1000);
      chk("next_hdr_latency", 512'(last_acc - n), 512'd3);
      send_body(32'hA020_1000, 32'h3000_0000, 1'b1);
      idle(4);
      chk("b2b_error", {511'd0, Error}, 512'd0);

      // Reset after seven data words, then a clean frame.
      send(32'hA040_6000);
      for (int r = 0; r < 7; r++) send(32'h6600_0000 + 32'(r));
      idle(1);
      do_reset();
      chk("post_rst_row0", {480'd0, FrameData[31:0]}, 512'd0);
      send(32'hA040_6000);
      send_body(32'hA040_6000, 32'h4000_0000, 1'b1);
      idle(4);

`ifdef CONFIG_CRC_EN
      // Corrupted check word: rows stay overwritten, no strobe, Error set.
      send(32'hA050_2000);
      send_body(32'hA050_2000, 32'h8000_0000, 1'b0);
      idle(4);
      chk("crc_bad_error", {511'd0, Error}, 512'd1);
      chk("crc_bad_row0", {480'd0, FrameData[31:0]}, {480'd0, 32'h8000_0000});
      chk("crc_bad_busy", {511'd0, Busy}, 512'd0);
`endif

      idle(5);
      chk("sb_empty", 512'(sb.size()), 512'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
